// File: rtl/dll_disc_seq.sv
`timescale 1ns/1ps
// DLL code-phase discriminator: tagged early/late I2Q2 pairs in, signed phase-increment
// correction out, using an in-domain restoring divider for the normalised mode.
//
// state | meaning
// IDLE  | waiting for a FIFO entry; pops and registers sum/|diff|/sign on exit
// NORM  | shift operands into OP_WIDTH (mode 0) or clamp |diff| (mode 1)
// MULT  | prod = diff_t * K
// DIV   | one restoring quotient bit per cycle, QW cycles
// DONE  | shift by S, saturate, apply sign, raise out_valid
// OUT   | hold result until accepted
module dll_disc_seq #(
    parameter int IN_WIDTH    = 24,
    parameter int OP_WIDTH    = 16,
    parameter int SCALE_WIDTH = 16,
    parameter int OUT_WIDTH   = 18,
    parameter int TAG_WIDTH   = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   global_reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   in_mode,
    input  logic [IN_WIDTH-1:0]    i2q2_early,
    input  logic [IN_WIDTH-1:0]    i2q2_late,
    input  logic [SCALE_WIDTH-1:0] scale,
    input  logic [4:0]             scale_shift,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TAG_WIDTH-1:0]   out_tag,
    output logic [OUT_WIDTH-1:0]   out_dphi,
    output logic                   out_sat
);

    localparam int QW  = OP_WIDTH + SCALE_WIDTH;
    localparam int SW  = IN_WIDTH + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = TAG_WIDTH + 1 + 2 * IN_WIDTH;
    localparam int CW  = $clog2(QW);
    localparam int SHW = $clog2(SW + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NORM = 3'd1;
    localparam logic [2:0] S_MULT = 3'd2;
    localparam logic [2:0] S_DIV  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    localparam logic [AW:0]          PTR_ONE   = 1;
    localparam logic [CW-1:0]        CNT_ONE   = 1;
    localparam logic [CW-1:0]        CNT_START = CW'(QW - 1);
    localparam logic [IN_WIDTH-1:0]  DIFF_CAP  = IN_WIDTH'((64'd1 << OP_WIDTH) - 64'd1);
    localparam logic [QW-1:0]        MAG_MAX   = QW'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;

    logic [TAG_WIDTH-1:0] h_tag;
    logic                 h_mode;
    logic [IN_WIDTH-1:0]  h_early;
    logic [IN_WIDTH-1:0]  h_late;

    logic [2:0]             state;
    logic [SW-1:0]          sum_r;
    logic [IN_WIDTH-1:0]    adiff_r;
    logic                   neg_r;
    logic [TAG_WIDTH-1:0]   tag_r;
    logic                   mode_r;
    logic [SCALE_WIDTH-1:0] scale_r;
    logic [4:0]             shift_r;
    logic [OP_WIDTH-1:0]    sum_t;
    logic [OP_WIDTH-1:0]    diff_t;
    logic [QW-1:0]          q_r;
    logic [OP_WIDTH-1:0]    rem_r;
    logic [CW-1:0]          div_cnt;

    logic [SW-1:0]        norm_max;
    logic [SHW-1:0]       norm_sh;
    logic [OP_WIDTH:0]    div_trial;
    logic                 div_ge;
    logic [QW-1:0]        done_mag;
    logic                 done_sat;
    logic [OUT_WIDTH-1:0] done_mag_c;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign {h_tag, h_mode, h_early, h_late} = fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {in_tag, in_mode, i2q2_early, i2q2_late};
        end
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    always_comb begin
        norm_max = (sum_r >= {1'b0, adiff_r}) ? sum_r : {1'b0, adiff_r};
        norm_sh  = '0;
        for (int i = 0; i < SW; i++) begin
            if (norm_max[i] && (i + 1 > OP_WIDTH)) begin
                norm_sh = SHW'(i + 1 - OP_WIDTH);
            end
        end
        div_trial  = {rem_r, q_r[QW-1]};
        div_ge     = (div_trial >= {1'b0, sum_t});
        done_mag   = q_r >> shift_r;
        done_sat   = (done_mag > MAG_MAX);
        done_mag_c = OUT_WIDTH'(done_sat ? MAG_MAX : done_mag);
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state     <= S_IDLE;
            rd_ptr    <= '0;
            sum_r     <= '0;
            adiff_r   <= '0;
            neg_r     <= 1'b0;
            tag_r     <= '0;
            mode_r    <= 1'b0;
            scale_r   <= '0;
            shift_r   <= '0;
            sum_t     <= '0;
            diff_t    <= '0;
            q_r       <= '0;
            rem_r     <= '0;
            div_cnt   <= '0;
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_dphi  <= '0;
            out_sat   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        rd_ptr  <= rd_ptr + PTR_ONE;
                        sum_r   <= SW'(h_early) + SW'(h_late);
                        adiff_r <= (h_late > h_early) ? h_late - h_early : h_early - h_late;
                        neg_r   <= (h_late > h_early);
                        tag_r   <= h_tag;
                        mode_r  <= h_mode;
                        scale_r <= scale;
                        shift_r <= scale_shift;
                        state   <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (!mode_r) begin
                        sum_t  <= OP_WIDTH'(sum_r >> norm_sh);
                        diff_t <= OP_WIDTH'(adiff_r >> norm_sh);
                    end else begin
                        diff_t <= OP_WIDTH'((adiff_r > DIFF_CAP) ? DIFF_CAP : adiff_r);
                    end
                    state <= S_MULT;
                end
                S_MULT: begin
                    // The product register doubles as the dividend/quotient shift register.
                    if (!mode_r && (sum_t != '0)) begin
                        q_r     <= QW'(diff_t) * QW'(scale_r);
                        rem_r   <= '0;
                        div_cnt <= CNT_START;
                        state   <= S_DIV;
                    end else begin
                        q_r   <= mode_r ? QW'(diff_t) * QW'(scale_r) : '0;
                        state <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem_r <= OP_WIDTH'(div_ge ? div_trial - {1'b0, sum_t} : div_trial);
                    q_r   <= {q_r[QW-2:0], div_ge};
                    if (div_cnt == '0) begin
                        state <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt - CNT_ONE;
                    end
                end
                S_DONE: begin
                    out_tag   <= tag_r;
                    out_sat   <= done_sat;
                    out_dphi  <= neg_r ? -done_mag_c : done_mag_c;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dll_disc_seq.sv
`timescale 1ns/1ps
// Self-checking bench for dll_disc_seq: directed cases, backpressure, reset abort,
// then randomized transactions against an arithmetic reference model.
module tb_dll_disc_seq;

    localparam int  OP_WIDTH  = 16;
    localparam int  OUT_WIDTH = 18;
    localparam longint MAXO   = (64'd1 << (OUT_WIDTH - 1)) - 1;

    logic        clk = 1'b0;
    logic        global_reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_tag;
    logic        in_mode;
    logic [23:0] i2q2_early;
    logic [23:0] i2q2_late;
    logic [15:0] scale;
    logic [4:0]  scale_shift;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_tag;
    logic [17:0] out_dphi;
    logic        out_sat;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dll_disc_seq dut (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_tag         (in_tag),
        .in_mode        (in_mode),
        .i2q2_early     (i2q2_early),
        .i2q2_late      (i2q2_late),
        .scale          (scale),
        .scale_shift    (scale_shift),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .out_dphi       (out_dphi),
        .out_sat        (out_sat)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: dphi from the discriminator formulas with plain integer arithmetic.
    function automatic void model(input bit mode, input longint e, input longint l,
                                  input longint k, input longint s,
                                  output longint dphi, output bit sat, output bit did_div);
        longint sum, ad, big, st, dt, q, mag;
        int sh;
        sum = e + l;
        ad  = (e > l) ? e - l : l - e;
        big = (sum > ad) ? sum : ad;
        did_div = 1'b0;
        if (!mode) begin
            sh = 0;
            while ((big >> sh) >= (longint'(1) << OP_WIDTH)) sh++;
            st = sum >> sh;
            dt = ad >> sh;
            if (st == 0) q = 0;
            else begin
                q = (dt * k) / st;
                did_div = 1'b1;
            end
        end else begin
            dt = (ad > (longint'(1) << OP_WIDTH) - 1) ? (longint'(1) << OP_WIDTH) - 1 : ad;
            q  = dt * k;
        end
        mag = q >> s;
        sat = (mag > MAXO);
        if (sat) mag = MAXO;
        dphi = (l > e) ? -mag : mag;
    endfunction

    task automatic run_one(input string name, input logic [3:0] tag, input bit mode,
                           input logic [23:0] e, input logic [23:0] l,
                           input logic [15:0] k, input logic [4:0] s,
                           input longint exp_dphi, input bit exp_sat, input int exp_lat);
        int lat;
        in_tag = tag; in_mode = mode; i2q2_early = e; i2q2_late = l;
        scale = k; scale_shift = s; in_valid = 1'b1;
        check({name, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_tag"}, out_tag, tag);
        check({name, "_dphi"}, $signed(out_dphi), exp_dphi);
        check({name, "_sat"}, out_sat, exp_sat);
        @(posedge clk); #1;
        check({name, "_ack"}, out_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

    initial begin
        int     n_acc, w, extra, sel;
        bit     rdy, mode, sat, did_div;
        longint dphi;
        logic [23:0] e, l;
        logic [15:0] k;
        logic [4:0]  s;

        global_reset_n = 1'b0;
        in_valid = 1'b0; in_tag = '0; in_mode = 1'b0;
        i2q2_early = '0; i2q2_late = '0; scale = '0; scale_shift = '0;
        out_ready = 1'b1;
        #23;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_out_dphi", out_dphi, 0);
        check("rst_out_sat", out_sat, 0);
        @(negedge clk) global_reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        run_one("norm_pos", 4'd1, 1'b0, 24'd3000, 24'd1000, 16'd16384, 5'd8, 32, 1'b0, 36);
        run_one("norm_neg", 4'd2, 1'b0, 24'd1000, 24'd3000, 16'd16384, 5'd8, -32, 1'b0, 36);
        run_one("trunc", 4'd3, 1'b0, 24'h800000, 24'd0, 16'd16384, 5'd8, 64, 1'b0, 36);
        run_one("unnorm", 4'd4, 1'b1, 24'd100, 24'd300, 16'd256, 5'd8, -200, 1'b0, 4);
        run_one("unnorm_sat", 4'd5, 1'b1, 24'hFFFF, 24'd0, 16'hFFFF, 5'd8, 131071, 1'b1, 4);
        run_one("zero_sum", 4'd6, 1'b0, 24'd0, 24'd0, 16'd16384, 5'd8, 0, 1'b0, 4);
        run_one("equal_norm", 4'd7, 1'b0, 24'd5000, 24'd5000, 16'd16384, 5'd8, 0, 1'b0, 36);
        run_one("equal_unnorm", 4'd8, 1'b1, 24'd5000, 24'd5000, 16'hFFFF, 5'd0, 0, 1'b0, 4);

        // Backpressure: consumer stalled while the producer keeps offering tags 0..7.
        out_ready = 1'b0; in_mode = 1'b1; i2q2_late = '0; scale = 16'd256; scale_shift = 5'd8;
        in_valid = 1'b1; in_tag = 4'd0; i2q2_early = 24'd100; n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            rdy = in_ready;
            @(posedge clk); #1;
            if (rdy) begin
                n_acc++;
                in_tag = 4'(n_acc);
                i2q2_early = 24'(100 * (n_acc + 1));
            end
            if (i == 3) check("bp_ready_edge3", in_ready, 1);
            if (i == 4) check("bp_ready_edge4", in_ready, 0);
        end
        in_valid = 1'b0;
        check("bp_accepted", n_acc, 5);
        check("bp_first_valid", out_valid, 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_tag", out_tag, 0);
        check("bp_hold_dphi", $signed(out_dphi), 100);
        out_ready = 1'b1;
        for (int t = 0; t < 5; t++) begin
            w = 0;
            while (!out_valid && w < 50) begin
                @(posedge clk); #1;
                w++;
            end
            check("bp_drain_valid", out_valid, 1);
            check("bp_drain_tag", out_tag, t);
            check("bp_drain_dphi", $signed(out_dphi), 100 * (t + 1));
            @(posedge clk); #1;
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("bp_no_extra", extra, 0);

        // Reset while dividing with two entries queued behind the active one.
        in_mode = 1'b0; i2q2_early = 24'd3000; i2q2_late = 24'd1000;
        scale = 16'd16384; scale_shift = 5'd8; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_tag = 4'(9 + i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        global_reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        @(negedge clk) global_reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_in_ready", in_ready, 1);
        extra = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (out_valid) extra++;
        end
        check("rst_mid_no_stale", extra, 0);
        run_one("post_reset", 4'd3, 1'b0, 24'd1000, 24'd3000, 16'd16384, 5'd8, -32, 1'b0, 36);

        for (int r = 0; r < 24; r++) begin
            mode = 1'($urandom_range(0, 1));
            sel  = $urandom_range(0, 3);
            case (sel)
                0: begin e = 24'($urandom_range(0, 4095)); l = 24'($urandom_range(0, 4095)); end
                1: begin e = 24'($urandom); l = 24'($urandom); end
                2: begin e = 24'($urandom); l = e; end
                default: begin e = 24'($urandom_range(0, 65535)); l = 24'($urandom_range(0, 131071)); end
            endcase
            k = 16'($urandom);
            s = 5'($urandom_range(0, 12));
            model(mode, longint'(e), longint'(l), longint'(k), longint'(s), dphi, sat, did_div);
            run_one("rand", 4'(r), mode, e, l, k, s, dphi, sat, did_div ? 36 : 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
